// File: rtl/axi_lite_regtest_master.sv
// AXI4-Lite register self-test master: writes a seed-derived pattern to a block
// of slave registers, reads each back, and reports pass/fail with first-error details.
module axi_lite_regtest_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_ADDR_STRIDE      = 4,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [15:0]                       err_count,
  output logic [7:0]                        first_err_idx,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     first_err_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int TW = $clog2(C_TIMEOUT_CYCLES) + 1;
  localparam logic [7:0]    LAST_IDX = 8'(C_NUM_REGS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_ABORT, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic             r_awvalid, r_wvalid, r_arvalid;
  logic             r_aw_done, r_w_done, r_ar_done;
  logic [7:0]       r_idx;
  logic [TW-1:0]    r_tcnt;
  logic             r_pat, r_order, r_timeout, r_pass;
  logic [DW-1:0]    r_seed;
  logic [15:0]      r_err_cnt;
  logic [7:0]       r_err_idx;
  logic [DW-1:0]    r_err_data;

  logic             w_bready, w_rready;
  logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic             w_last, w_tmo, w_rd_bad, w_err_ev, w_quiet;
  logic             w_start, w_enter_wr, w_enter_rd;
  logic [DW-1:0]    w_data;
  logic [AW-1:0]    w_addr;

  assign w_data   = (r_seed + DW'(r_idx)) ^ {DW{r_pat}};
  assign w_addr   = C_BASE_ADDR + AW'(r_idx) * AW'(C_ADDR_STRIDE);
  assign w_bready = (r_state == S_WR_RESP) || (r_state == S_ABORT);
  assign w_rready = (r_state == S_RD_RESP) || (r_state == S_ABORT);
  assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid & M_AXI_WREADY;
  assign w_b_hs   = M_AXI_BVALID & w_bready;
  assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs   = M_AXI_RVALID & w_rready;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_tmo    = (r_tcnt == TMO_LAST);
  assign w_start  = (r_state == S_IDLE) && start;
  assign w_rd_bad = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != w_data);
  assign w_err_ev = ((r_state == S_WR_RESP) && w_b_hs && (M_AXI_BRESP != 2'b00)) ||
                    ((r_state == S_RD_RESP) && w_r_hs && w_rd_bad);
  // Abort may only retire once every issued request has been accepted and answered.
  assign w_quiet  = !(r_awvalid | r_wvalid | r_arvalid | r_aw_done | r_w_done | r_ar_done);
  assign w_enter_wr = (w_next == S_WR_REQ) && (r_state != S_WR_REQ);
  assign w_enter_rd = (w_next == S_RD_REQ) && (r_state != S_RD_REQ);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_WR_REQ;
      S_WR_REQ: begin
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = S_WR_RESP;
        else if (w_tmo)                                   w_next = S_ABORT;
      end
      S_WR_RESP: begin
        if (w_b_hs)     w_next = (r_order && !w_last) ? S_WR_REQ : S_RD_REQ;
        else if (w_tmo) w_next = S_ABORT;
      end
      S_RD_REQ: begin
        if (w_ar_hs)    w_next = S_RD_RESP;
        else if (w_tmo) w_next = S_ABORT;
      end
      S_RD_RESP: begin
        if (w_r_hs)     w_next = w_last ? S_DONE : (r_order ? S_RD_REQ : S_WR_REQ);
        else if (w_tmo) w_next = S_ABORT;
      end
      S_ABORT:   if (w_quiet) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ar_done  <= 1'b0;
      r_idx      <= '0;
      r_tcnt     <= '0;
      r_pat      <= 1'b0;
      r_order    <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_err_idx  <= '0;
      r_err_data <= '0;
    end else begin
      if (w_enter_wr) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end
      if (w_enter_rd)   r_arvalid <= 1'b1;
      else if (w_ar_hs) r_arvalid <= 1'b0;

      if (w_b_hs) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (w_ar_hs)     r_ar_done <= 1'b1;
      else if (w_r_hs) r_ar_done <= 1'b0;

      if (w_next != r_state) r_tcnt <= '0;
      else if (!w_tmo)       r_tcnt <= r_tcnt + 1'b1;

      if ((r_state == S_WR_RESP) && w_b_hs && r_order)
        r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
      if ((r_state == S_RD_RESP) && w_r_hs && !w_last)
        r_idx <= r_idx + 8'd1;

      if (w_err_ev) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0) begin
          r_err_idx  <= r_idx;
          r_err_data <= (r_state == S_RD_RESP) ? M_AXI_RDATA : '0;
        end
      end
      if ((w_next == S_ABORT) && (r_state != S_ABORT)) r_timeout <= 1'b1;
      if ((w_next == S_DONE) && (r_state != S_DONE))
        r_pass <= !r_timeout && (r_err_cnt == 16'd0) && !w_err_ev;

      if (w_start) begin
        r_pat      <= mode[0];
        r_order    <= mode[1];
        r_idx      <= '0;
        r_timeout  <= 1'b0;
        r_pass     <= 1'b0;
        r_err_cnt  <= '0;
        r_err_idx  <= '0;
        r_err_data <= '0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_start) r_seed <= seed;
  end

  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err_cnt;
  assign first_err_idx  = r_err_idx;
  assign first_err_data = r_err_data;
  assign M_AXI_AWADDR   = w_addr;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_WDATA    = w_data;
  assign M_AXI_WSTRB    = '1;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_BREADY   = w_bready;
  assign M_AXI_ARADDR   = w_addr;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARVALID  = r_arvalid;
  assign M_AXI_RREADY   = w_rready;

endmodule

// File: tb/tb_axi_lite_regtest_master.sv
// Bench for axi_lite_regtest_master: a 4-register AXI4-Lite slave with fault
// injection and random stalls, checked against a per-register error model.
module tb_axi_lite_regtest_master;

  logic        ACLK, ARESETN, start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [7:0]  first_err_idx;
  logic [31:0] first_err_data;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi_lite_regtest_master #(.C_TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation
  logic [31:0] sreg [4];
  logic [31:0] stuck [4];
  logic [1:0]  bresp_cfg [4];
  logic [1:0]  rresp_cfg [4];
  bit          stall, aw_lag, ar_dead;
  int          n_aw, n_w, n_b, n_ar, n_r, aw_at_first_ar, viol;

  // Slave: handshakes seen at one negedge complete on the following posedge
  initial begin : slave
    bit have_aw, have_w, b_pend, have_ar;
    bit p_aw, p_w, p_b, p_ar, p_r, v_aw, v_w, v_ar;
    bit rdy;
    logic [31:0] aw_a, w_d, ar_a, p_awaddr, p_wdata, p_araddr;
    int b_dly, r_dly, w_since, aw_low, w_low, ar_low;
    {have_aw, have_w, b_pend, have_ar} = '0;
    {p_aw, p_w, p_b, p_ar, p_r, v_aw, v_w, v_ar} = '0;
    {aw_a, w_d, ar_a, p_awaddr, p_wdata, p_araddr} = '0;
    b_dly = 0; r_dly = 0; w_since = 0; aw_low = 0; w_low = 0; ar_low = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {have_aw, have_w, b_pend, have_ar} = '0;
        {p_aw, p_w, p_b, p_ar, p_r, v_aw, v_w, v_ar} = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        continue;
      end
      if (v_aw && !p_aw && !M_AXI_AWVALID) viol++;
      if (v_w  && !p_w  && !M_AXI_WVALID)  viol++;
      if (v_ar && !p_ar && !M_AXI_ARVALID) viol++;
      if (p_aw) begin have_aw = 1; aw_a = p_awaddr; n_aw++; end
      if (p_w) begin have_w = 1; w_d = p_wdata; n_w++; w_since = 0; end
      else w_since++;
      if (p_b) begin M_AXI_BVALID = 0; b_pend = 0; have_aw = 0; have_w = 0; n_b++; end
      if (p_ar) begin
        have_ar = 1; ar_a = p_araddr;
        if (n_ar == 0) aw_at_first_ar = n_aw;
        n_ar++;
        r_dly = stall ? int'($urandom_range(0, 3)) : 0;
      end
      if (p_r) begin M_AXI_RVALID = 0; have_ar = 0; n_r++; end
      if (have_aw && have_w && !b_pend) begin
        if (aw_a[31:4] != 0) viol++;
        sreg[aw_a[3:2]] = w_d & ~stuck[aw_a[3:2]];
        b_pend = 1;
        b_dly = stall ? int'($urandom_range(0, 3)) : 0;
      end
      if (b_pend && !M_AXI_BVALID) begin
        if (b_dly == 0) begin M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg[aw_a[3:2]]; end
        else b_dly--;
      end
      if (have_ar && !M_AXI_RVALID) begin
        if (r_dly == 0) begin
          if (ar_a[31:4] != 0) viol++;
          M_AXI_RVALID = 1; M_AXI_RDATA = sreg[ar_a[3:2]]; M_AXI_RRESP = rresp_cfg[ar_a[3:2]];
        end else r_dly--;
      end
      rdy = !stall || ($urandom_range(0, 1) == 1) || (w_low >= 3);
      w_low = rdy ? 0 : w_low + 1;
      M_AXI_WREADY = !have_w && rdy;
      rdy = !stall || ($urandom_range(0, 1) == 1) || (aw_low >= 3);
      aw_low = rdy ? 0 : aw_low + 1;
      if (aw_lag) M_AXI_AWREADY = !have_aw && have_w && (w_since >= 4);
      else        M_AXI_AWREADY = !have_aw && rdy;
      rdy = !stall || ($urandom_range(0, 1) == 1) || (ar_low >= 3);
      ar_low = rdy ? 0 : ar_low + 1;
      M_AXI_ARREADY = !ar_dead && !have_ar && rdy;
      p_aw = M_AXI_AWVALID && M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR; v_aw = M_AXI_AWVALID;
      p_w  = M_AXI_WVALID && M_AXI_WREADY;   p_wdata  = M_AXI_WDATA;  v_w  = M_AXI_WVALID;
      p_ar = M_AXI_ARVALID && M_AXI_ARREADY; p_araddr = M_AXI_ARADDR; v_ar = M_AXI_ARVALID;
      p_b  = M_AXI_BVALID && M_AXI_BREADY;
      p_r  = M_AXI_RVALID && M_AXI_RREADY;
    end
  end

  // Reference: walk the transaction sequence implied by the order bit
  logic [31:0] exp_d [4];
  int          e_cnt, e_idx;
  logic [31:0] e_data;

  task automatic model(input logic [1:0] md, input logic [31:0] sd);
    int seq_rd [8];
    int seq_i [8];
    logic [31:0] rb;
    bit bad;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = md[0] ? ~(sd + 32'(i)) : sd + 32'(i);
      if (md[1]) begin
        seq_rd[i] = 0; seq_i[i] = i; seq_rd[i+4] = 1; seq_i[i+4] = i;
      end else begin
        seq_rd[2*i] = 0; seq_i[2*i] = i; seq_rd[2*i+1] = 1; seq_i[2*i+1] = i;
      end
    end
    e_cnt = 0; e_idx = 0; e_data = 0;
    for (int k = 0; k < 8; k++) begin
      rb  = exp_d[seq_i[k]] & ~stuck[seq_i[k]];
      bad = seq_rd[k] ? (rresp_cfg[seq_i[k]] != 0 || rb != exp_d[seq_i[k]])
                      : (bresp_cfg[seq_i[k]] != 0);
      if (bad) begin
        if (e_cnt == 0) begin e_idx = seq_i[k]; e_data = seq_rd[k] ? rb : 32'h0; end
        e_cnt++;
      end
    end
  endtask

  task automatic run_test(input string nm, input logic [1:0] md, input logic [31:0] sd, input bit extra);
    bit seen;
    model(md, sd);
    for (int i = 0; i < 4; i++) sreg[i] = ~exp_d[i] ^ 32'h1;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_at_first_ar = -1; viol = 0;
    @(negedge ACLK);
    mode = md; seed = sd; start = 1;
    @(negedge ACLK);
    start = 0; mode = ~md; seed = ~sd;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_awv_wv"}, {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge ACLK);
      start = (extra && c == 6);
      if (done) seen = 1;
    end
    start = 0;
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_pass"}, pass, (e_cnt == 0));
    chk({nm, "_err_count"}, err_count, e_cnt);
    chk({nm, "_first_idx"}, first_err_idx, e_idx);
    chk({nm, "_first_data"}, first_err_data, e_data);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_busy_at_done"}, busy, 0);
    @(negedge ACLK);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_pass_hold"}, pass, (e_cnt == 0));
    chk({nm, "_hs_counts"}, {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)}, 40'h0404040404);
    chk({nm, "_aw_before_ar"}, aw_at_first_ar, md[1] ? 4 : 1);
    chk({nm, "_protocol"}, viol, 0);
    for (int i = 0; i < 4; i++) chk({nm, "_reg"}, sreg[i], exp_d[i] & ~stuck[i]);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 4; i++) begin stuck[i] = 0; bresp_cfg[i] = 0; rresp_cfg[i] = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    logic [1:0] md;
    ARESETN = 0; start = 0; mode = 0; seed = 0;
    stall = 0; aw_lag = 0; ar_dead = 0;
    clear_faults();
    for (int i = 0; i < 4; i++) sreg[i] = 0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;
    @(negedge ACLK);
    chk("rst_status", {busy, done, pass, timeout}, 4'b0000);
    chk("rst_err", {err_count, first_err_idx, first_err_data}, 56'h0);
    chk("rst_handshake", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    chk("rst_prot_strb", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 10'h00F);

    run_test("t1", 2'b00, 32'h0101FFFF, 0);
    chk("t1_vals", {sreg[0], sreg[1], sreg[2], sreg[3]}, 128'h0101FFFF_01020000_01020001_01020002);

    stall = 1;
    run_test("t2", 2'b11, 32'hFFFFFFFE, 0);
    chk("t2_vals", {sreg[0], sreg[1], sreg[2], sreg[3]}, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE);

    stuck[2] = 32'h10;
    run_test("t3", 2'b00, 32'hdead0011, 0);
    chk("t3_summary", {pass, err_count, first_err_idx, first_err_data}, {1'b0, 16'd1, 8'd2, 32'hdead0003});
    clear_faults();

    bresp_cfg[1] = 2'b10; rresp_cfg[3] = 2'b01;
    run_test("t4", 2'b00, $urandom, 0);
    chk("t4_summary", {pass, err_count, first_err_idx, first_err_data}, {1'b0, 16'd2, 8'd1, 32'h0});
    clear_faults();

    for (int k = 0; k < 6; k++) begin
      aw_lag = (k < 3);
      for (int i = 0; i < 4; i++) begin
        stuck[i]     = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        bresp_cfg[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        rresp_cfg[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      md = 2'($urandom_range(0, 3));
      run_test("t5", md, $urandom, 1);
    end
    clear_faults();
    aw_lag = 0;

    stall = 0; ar_dead = 1;
    @(negedge ACLK);
    mode = 2'b00; seed = $urandom; start = 1;
    @(negedge ACLK);
    start = 0;
    cnt = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (timeout) seen = 1;
      else begin
        if (M_AXI_ARVALID) cnt++;
        @(negedge ACLK);
      end
    end
    chk("t6_timeout_seen", seen, 1);
    chk("t6_timeout_cycle", cnt, 16);
    chk("t6_stuck_state", {M_AXI_ARVALID, busy, done}, 3'b110);
    repeat (4) @(negedge ACLK);
    seed = ~seed; start = 1;
    @(negedge ACLK);
    start = 0;
    repeat (3) @(negedge ACLK);
    chk("t6_still_abort", {M_AXI_ARVALID, busy, timeout, done, M_AXI_RREADY}, 5'b11101);
    @(posedge ACLK); #1 ARESETN = 0;
    @(posedge ACLK); #1 ARESETN = 1;
    @(negedge ACLK);
    chk("t6_rst_status", {busy, done, pass, timeout}, 4'b0000);
    chk("t6_rst_err", {err_count, first_err_idx, first_err_data}, 56'h0);
    chk("t6_rst_handshake", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    ar_dead = 0; stall = 1;
    run_test("t6_recover", 2'b01, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
